// File: rtl/bforge_apb_lib_pkg.sv
// Shared APB widths, completer state encoding and response codes.
package bforge_apb_lib_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } bforge_apb_cmp_state_e;

  localparam logic APB_RESP_OKAY   = 1'b0;
  localparam logic APB_RESP_SLVERR = 1'b1;
endpackage

// File: rtl/bforge_apb_if.sv
// APB4 bus bundle; master drives the request, slave returns the response.
interface bforge_apb_if;
  import bforge_apb_lib_pkg::*;

  logic                  psel;
  logic                  penable;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/bforge_apb_cmp_decode.sv
// Combinational register decode: word index, hit and error for one APB address.
module bforge_apb_cmp_decode
  import bforge_apb_lib_pkg::*;
#(
  parameter int                    NUM_REGS  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [NUM_REGS-1:0]   RO_MASK   = '0,
  parameter int                    IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  write_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  hit_o,
  output logic                  ro_o,
  output logic                  err_o
);
  localparam int LSB = $clog2(STRB_WIDTH);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word;

  always_comb begin
    offset = addr_i - BASE_ADDR;
    word   = offset >> LSB;
    idx_o  = word[IDX_W-1:0];
    hit_o  = (addr_i >= BASE_ADDR) && (word < ADDR_WIDTH'(NUM_REGS))
             && (addr_i[LSB-1:0] == '0);
    ro_o   = hit_o && RO_MASK[idx_o];
    err_o  = !hit_o || (write_i && ro_o);
  end
endmodule

// File: rtl/bforge_apb_completer.sv
// APB4 completer: register bank with byte-strobe writes, fixed wait states and PSLVERR.
module bforge_apb_completer
  import bforge_apb_lib_pkg::*;
#(
  parameter int                    NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                           pclk,
  input  logic                           preset,
  bforge_apb_if.slave                    apb,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int LSB   = $clog2(STRB_WIDTH);
  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_ACCESS = ACCESS;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic [0:0]            state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  pready_q, pready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic [DATA_WIDTH-1:0] status_q, status_d;
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;

  logic [DATA_WIDTH-1:0] rw_val     [NUM_REGS];
  logic [DATA_WIDTH-1:0] status_arr [NUM_REGS];
  logic [IDX_W-1:0]      dec_idx, setup_idx;
  logic                  dec_hit, dec_ro, dec_err;
  logic                  complete, commit;
  logic [DATA_WIDTH-1:0] rd_val;

  bforge_apb_cmp_decode #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR),
    .RO_MASK   (RO_MASK),
    .IDX_W     (IDX_W)
  ) u_decode (
    .addr_i  (addr_q),
    .write_i (write_q),
    .idx_o   (dec_idx),
    .hit_o   (dec_hit),
    .ro_o    (dec_ro),
    .err_o   (dec_err)
  );

  // Status of an RO register is snapshotted in the setup cycle, so index the live address.
  assign setup_idx = IDX_W'((apb.paddr - BASE_ADDR) >> LSB);

  assign complete = (state_q == ST_ACCESS) && apb.psel && apb.penable && pready_q;
  assign commit   = complete && write_q && !dec_err && (strb_q != '0);

  always_comb begin
    rd_val = rw_val[dec_idx];
    if (dec_hit && dec_ro) rd_val = status_q;
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    pready_d = pready_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    status_d = status_q;
    pulse_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (apb.psel && !apb.penable) begin
          state_d  = ST_ACCESS;
          addr_d   = apb.paddr;
          write_d  = apb.pwrite;
          wdata_d  = apb.pwdata;
          strb_d   = apb.pstrb;
          status_d = status_arr[setup_idx];
          wcnt_d   = WAIT_INIT;
          pready_d = (WAIT_STATES == 0);
        end
      end
      ST_ACCESS: begin
        if (!apb.psel) begin
          state_d  = ST_IDLE;
          pready_d = 1'b0;
        end else if (apb.penable) begin
          if (pready_q) begin
            state_d  = ST_IDLE;
            pready_d = 1'b0;
            if (commit) pulse_d[dec_idx] = 1'b1;
          end else if (wcnt_q != '0) begin
            wcnt_d = wcnt_q - 4'd1;
            if (wcnt_q == 4'd1) pready_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      pready_q <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      status_q <= '0;
      pulse_q  <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      pready_q <= pready_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      status_q <= status_d;
      pulse_q  <= pulse_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign status_arr[gi] = status_i[gi*DATA_WIDTH +: DATA_WIDTH];
      if (RO_MASK[gi]) begin : g_ro
        assign rw_val[gi] = '0;
      end else begin : g_rw
        logic [DATA_WIDTH-1:0] data_q, data_d;
        always_comb begin
          data_d = data_q;
          if (commit && (dec_idx == IDX_W'(gi))) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
              if (strb_q[b]) data_d[b*8 +: 8] = wdata_q[b*8 +: 8];
            end
          end
        end
        always_ff @(posedge pclk) begin
          if (preset) data_q <= RESET_VAL;
          else        data_q <= data_d;
        end
        assign rw_val[gi] = data_q;
      end
      assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = rw_val[gi];
    end
  endgenerate

  assign reg_wr_pulse = pulse_q;
  assign apb.pready   = pready_q;
  assign apb.pslverr  = (complete && dec_err) ? APB_RESP_SLVERR : APB_RESP_OKAY;
  assign apb.prdata   = (complete && !dec_err && !write_q) ? rd_val : '0;
endmodule

// File: tb/tb_bforge_apb_completer.sv
// Directed bench: three completers (0, 3 and 2 wait states) share one requester model.
module tb_bforge_apb_completer;
  import bforge_apb_lib_pkg::*;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        preset, rst_c, rst_cc;
  int          unit;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  int          checks = 0;
  int          errors = 0;

  logic [511:0] status_a, status_0, reg_a, reg_b, reg_c;
  logic [15:0]  pulse_a, pulse_b, pulse_c;
  logic         m_pready, m_pslverr;
  logic [31:0]  m_prdata;
  logic [511:0] m_reg;
  logic [15:0]  m_pulse;

  assign status_a = {416'h0, 32'hCAFE0002, 64'h0};
  assign status_0 = '0;
  assign rst_cc   = preset | rst_c;

  bforge_apb_if ia ();
  bforge_apb_if ib ();
  bforge_apb_if ic ();

  assign ia.psel = psel & (unit == 0); assign ia.penable = penable; assign ia.paddr = paddr;
  assign ia.pwrite = pwrite; assign ia.pwdata = pwdata; assign ia.pstrb = pstrb;
  assign ib.psel = psel & (unit == 1); assign ib.penable = penable; assign ib.paddr = paddr;
  assign ib.pwrite = pwrite; assign ib.pwdata = pwdata; assign ib.pstrb = pstrb;
  assign ic.psel = psel & (unit == 2); assign ic.penable = penable; assign ic.paddr = paddr;
  assign ic.pwrite = pwrite; assign ic.pwdata = pwdata; assign ic.pstrb = pstrb;

  bforge_apb_completer #(.NUM_REGS(16), .BASE_ADDR(32'h0), .WAIT_STATES(0),
    .RO_MASK(16'h0004), .RESET_VAL(32'h11223344)) dut_a (
    .pclk(pclk), .preset(preset), .apb(ia), .status_i(status_a),
    .reg_q(reg_a), .reg_wr_pulse(pulse_a));

  bforge_apb_completer #(.NUM_REGS(16), .BASE_ADDR(32'h0), .WAIT_STATES(3),
    .RO_MASK(16'h0000), .RESET_VAL(32'h0)) dut_b (
    .pclk(pclk), .preset(preset), .apb(ib), .status_i(status_0),
    .reg_q(reg_b), .reg_wr_pulse(pulse_b));

  bforge_apb_completer #(.NUM_REGS(16), .BASE_ADDR(32'h0), .WAIT_STATES(2),
    .RO_MASK(16'h0000), .RESET_VAL(32'h5A5A5A5A)) dut_c (
    .pclk(pclk), .preset(rst_cc), .apb(ic), .status_i(status_0),
    .reg_q(reg_c), .reg_wr_pulse(pulse_c));

  always_comb begin
    m_pready = ia.pready; m_pslverr = ia.pslverr; m_prdata = ia.prdata;
    m_reg = reg_a; m_pulse = pulse_a;
    if (unit == 1) begin
      m_pready = ib.pready; m_pslverr = ib.pslverr; m_prdata = ib.prdata;
      m_reg = reg_b; m_pulse = pulse_b;
    end else if (unit == 2) begin
      m_pready = ic.pready; m_pslverr = ic.pslverr; m_prdata = ic.prdata;
      m_reg = reg_c; m_pulse = pulse_c;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge; samples the completion
  // cycle on the falling edge and the following cycle just after the next rise.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic err,
                      output int waits, output logic side, output logic [15:0] post_pulse,
                      output logic post_rdy);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0; side = 1'b0; rd = '0; err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (m_pready) begin
        rd = m_prdata; err = m_pslverr;
        break;
      end
      waits++;
      side = side | m_pslverr | (|m_prdata);
      @(posedge pclk); #1;
    end
    if (waits >= 20) waits = -1;
    @(posedge pclk); #1;
    post_pulse = m_pulse; post_rdy = m_pready;
    $display("xfer unit=%0d wr=%0d addr=%h wdata=%h strb=%b -> rdata=%h err=%0d waits=%0d pulse=%h",
             unit, wr, a, d, s, rd, err, waits, post_pulse);
  endtask

  task automatic idle();
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  logic [31:0] rd;
  logic        err, side, prdy;
  int          waits;
  logic [15:0] pp;

  initial begin
    unit = 0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; rst_c = 1'b0; preset = 1'b1;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;

    chk("rst_pready", 64'(m_pready), 64'd0);
    chk("rst_pslverr", 64'(m_pslverr), 64'd0);
    chk("rst_prdata", 64'(m_prdata), 64'd0);
    chk("rst_pulse", 64'(pulse_a), 64'd0);
    chk("rst_reg_a3", 64'(reg_a[127:96]), 64'h11223344);
    chk("rst_reg_c1", 64'(reg_c[63:32]), 64'h5A5A5A5A);

    xfer(1'b0, 32'h0C, 32'h0, 4'h0, rd, err, waits, side, pp, prdy);
    chk("rd3_data", 64'(rd), 64'h11223344);
    chk("rd3_err", 64'(err), 64'd0);
    chk("rd3_waits", 64'(waits), 64'd0);
    chk("rd3_pready_after", 64'(prdy), 64'd0);
    idle();

    // Lanes 0 and 2 take DD and BB; lanes 1 and 3 keep 33 and 11.
    xfer(1'b1, 32'h04, 32'hAABBCCDD, 4'b0101, rd, err, waits, side, pp, prdy);
    chk("wr1_err", 64'(err), 64'd0);
    chk("wr1_pulse", 64'(pp), 64'h0002);
    chk("wr1_reg", 64'(reg_a[63:32]), 64'h11BB33DD);
    idle();
    chk("wr1_pulse_gone", 64'(pulse_a), 64'd0);

    xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, err, waits, side, pp, prdy);
    chk("rd1_data", 64'(rd), 64'h11BB33DD);
    idle();

    xfer(1'b0, 32'h08, 32'h0, 4'hF, rd, err, waits, side, pp, prdy);
    chk("ro_rd_data", 64'(rd), 64'hCAFE0002);
    chk("ro_rd_err", 64'(err), 64'd0);
    idle();

    xfer(1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, rd, err, waits, side, pp, prdy);
    chk("ro_wr_err", 64'(err), 64'd1);
    chk("ro_wr_pulse", 64'(pp), 64'd0);
    chk("ro_wr_pslverr_after", 64'(m_pslverr), 64'd0);
    idle();

    xfer(1'b0, 32'h40, 32'h0, 4'h0, rd, err, waits, side, pp, prdy);
    chk("oor_err", 64'(err), 64'd1);
    chk("oor_rdata", 64'(rd), 64'd0);
    idle();

    xfer(1'b1, 32'h02, 32'h0, 4'hF, rd, err, waits, side, pp, prdy);
    chk("mis_err", 64'(err), 64'd1);
    chk("mis_pulse", 64'(pp), 64'd0);
    chk("mis_reg0", 64'(reg_a[31:0]), 64'h11223344);
    idle();

    xfer(1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, rd, err, waits, side, pp, prdy);
    chk("strb0_err", 64'(err), 64'd0);
    chk("strb0_pulse", 64'(pp), 64'd0);
    chk("strb0_reg5", 64'(reg_a[191:160]), 64'h11223344);
    idle();

    unit = 1;
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, err, waits, side, pp, prdy);
    chk("ws3_waits", 64'(waits), 64'd3);
    chk("ws3_quiet_during_wait", 64'(side), 64'd0);
    chk("ws3_rdata", 64'(rd), 64'd0);
    idle();

    xfer(1'b1, 32'h08, 32'h12345678, 4'hF, rd, err, waits, side, pp, prdy);
    chk("b2b_wr_pulse", 64'(pp), 64'h0004);
    xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, err, waits, side, pp, prdy);
    chk("b2b_rd_data", 64'(rd), 64'h12345678);
    chk("b2b_rd_waits", 64'(waits), 64'd3);
    idle();

    unit = 2;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04;
    pwdata = 32'hDEADBEEF; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1; rst_c = 1'b1;
    @(posedge pclk); #1;
    rst_c = 1'b0; psel = 1'b0; penable = 1'b0;
    $display("xfer unit=2 wr=1 addr=00000004 reset during access");
    chk("rstmid_pready", 64'(m_pready), 64'd0);
    chk("rstmid_pulse", 64'(pulse_c), 64'd0);
    chk("rstmid_reg", 64'(reg_c[63:32]), 64'h5A5A5A5A);
    @(posedge pclk); #1;
    chk("rstmid_pulse_later", 64'(pulse_c), 64'd0);

    xfer(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, rd, err, waits, side, pp, prdy);
    chk("ws2_waits", 64'(waits), 64'd2);
    chk("ws2_reg", 64'(reg_c[63:32]), 64'hDEADBEEF);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
